// File: rtl/pdh_pkg.sv
// Shared widths, window config type and the rounding/saturation helpers used by the PDH demodulator.
// Pure declarations and functions: no latency, no backpressure.
package pdh_pkg;
  localparam int ADC_W  = 14;
  localparam int LO_W   = 16;
  localparam int S16_W  = 16;
  localparam int ACC_W  = 48;
  localparam int PROD_W = ADC_W + LO_W;
  localparam int CNT_W  = 15;

  localparam logic signed [ACC_W-1:0] S14_MIN = -48'sd8192;
  localparam logic signed [ACC_W-1:0] S14_MAX = 48'sd8191;

  typedef struct packed {
    logic [3:0]       avg_log2;
    logic [3:0]       gain_shift;
    logic [ADC_W-1:0] offset;
  } win_cfg_t;

  typedef struct packed {
    logic             sat;
    logic [S16_W-1:0] val;
  } sat_res_t;

  // Round half up, then arithmetic shift right.
  function automatic logic signed [ACC_W-1:0] round_shift_right(
    input logic signed [ACC_W-1:0] x,
    input logic [4:0]              sh
  );
    logic signed [ACC_W-1:0] rnd;
    rnd = '0;
    if (sh != 5'd0) rnd[sh - 5'd1] = 1'b1;
    return (x + rnd) >>> sh;
  endfunction

  function automatic sat_res_t sat_s14_from_wide(input logic signed [ACC_W-1:0] x);
    sat_res_t r;
    if (x > S14_MAX) begin
      r.sat = 1'b1;
      r.val = 16'h1FFF;
    end else if (x < S14_MIN) begin
      r.sat = 1'b1;
      r.val = 16'hE000;
    end else begin
      r.sat = 1'b0;
      r.val = x[S16_W-1:0];
    end
    return r;
  endfunction
endpackage

// File: rtl/pdh_err_demod_if.sv
// Sample, configuration and error-word signals of the PDH demodulator.
// No flow control: the consumer takes every err_valid_o pulse.
interface pdh_err_demod_if;
  import pdh_pkg::*;

  logic signed [ADC_W-1:0] adc_i;
  logic signed [LO_W-1:0]  lo_i;
  logic [3:0]              avg_log2_i;
  logic [3:0]              gain_shift_i;
  logic signed [ADC_W-1:0] offset_i;
  logic                    enable_i;
  logic signed [S16_W-1:0] err_o;
  logic                    err_valid_o;
  logic                    sat_o;

  modport master (
    output adc_i, lo_i, avg_log2_i, gain_shift_i, offset_i, enable_i,
    input  err_o, err_valid_o, sat_o
  );

  modport slave (
    input  adc_i, lo_i, avg_log2_i, gain_shift_i, offset_i, enable_i,
    output err_o, err_valid_o, sat_o
  );
endinterface

// File: rtl/pdh_boxcar_dump.sv
// Integrate-and-dump over 2^avg_log2 products; dump result is combinational in the cycle of the last sample.
// No backpressure; a low en_i discards the partial window.
module pdh_boxcar_dump
  import pdh_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en_i,
  input  logic                     v2_i,
  input  logic signed [PROD_W-1:0] prod_i,
  input  logic [3:0]               avg_log2_i,
  input  logic [3:0]               gain_shift_i,
  input  logic signed [ADC_W-1:0]  offset_i,
  output logic                     dump_vld_o,
  output logic [S16_W-1:0]         dump_dat_o,
  output logic                     dump_sat_o
);
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  win_cfg_t                cfg_q, cfg_d;

  logic                    first;
  win_cfg_t                live_cfg, eff_cfg;
  logic [CNT_W-1:0]        last;
  logic signed [ACC_W-1:0] sum, rounded, biased;
  logic [4:0]              sh;
  sat_res_t                res;

  always_comb begin
    first    = (cnt_q == '0);
    live_cfg = '{avg_log2: avg_log2_i, gain_shift: gain_shift_i, offset: offset_i};
    // The first sample of a window latches config, so it must also use it directly (matters for N=1).
    eff_cfg  = first ? live_cfg : cfg_q;
    last     = '0;
    for (int i = 0; i < CNT_W; i++) last[i] = (i < int'(eff_cfg.avg_log2));
    sum      = (first ? '0 : acc_q) + ACC_W'(prod_i);
    sh       = 5'd15 + {1'b0, eff_cfg.avg_log2} - {1'b0, eff_cfg.gain_shift};
    rounded  = round_shift_right(sum, sh);
    biased   = rounded + ACC_W'($signed(eff_cfg.offset));
    res      = sat_s14_from_wide(biased);

    dump_vld_o = en_i & v2_i & (cnt_q == last);
    dump_dat_o = res.val;
    dump_sat_o = res.sat;
  end

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    cfg_d = cfg_q;
    if (!en_i) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (v2_i) begin
      if (first) cfg_d = live_cfg;
      if (cnt_q == last) begin
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
      cfg_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      cfg_q <= cfg_d;
    end
  end
endmodule

// File: rtl/pdh_err_demod.sv
// PDH error front end: ADC x LO mix, boxcar low-pass, decimated saturated s14 error word; capture-to-output latency 2 clk.
// No backpressure: every err_valid_o pulse must be taken; enable_i low flushes and zeroes the output.
module pdh_err_demod
  import pdh_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  pdh_err_demod_if.slave  bus
);
  logic signed [ADC_W-1:0]  adc_q, adc_d;
  logic signed [LO_W-1:0]   lo_q, lo_d;
  logic                     v1_q, v1_d;
  logic signed [PROD_W-1:0] prod_q, prod_d;
  logic                     v2_q, v2_d;
  logic [S16_W-1:0]         err_q, err_d;
  logic                     err_valid_q, err_valid_d;
  logic                     sat_q, sat_d;

  logic                     dump_vld;
  logic [S16_W-1:0]         dump_dat;
  logic                     dump_sat;

  always_comb begin
    adc_d       = '0;
    lo_d        = '0;
    v1_d        = 1'b0;
    prod_d      = '0;
    v2_d        = 1'b0;
    err_d       = '0;
    err_valid_d = 1'b0;
    sat_d       = 1'b0;
    if (bus.enable_i) begin
      adc_d  = bus.adc_i;
      lo_d   = bus.lo_i;
      v1_d   = 1'b1;
      prod_d = PROD_W'(adc_q) * PROD_W'(lo_q);
      v2_d   = v1_q;
      err_d  = err_q;
      sat_d  = sat_q;
      if (dump_vld) begin
        err_d       = dump_dat;
        sat_d       = dump_sat;
        err_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      adc_q       <= '0;
      lo_q        <= '0;
      v1_q        <= 1'b0;
      prod_q      <= '0;
      v2_q        <= 1'b0;
      err_q       <= '0;
      err_valid_q <= 1'b0;
      sat_q       <= 1'b0;
    end else begin
      adc_q       <= adc_d;
      lo_q        <= lo_d;
      v1_q        <= v1_d;
      prod_q      <= prod_d;
      v2_q        <= v2_d;
      err_q       <= err_d;
      err_valid_q <= err_valid_d;
      sat_q       <= sat_d;
    end
  end

  pdh_boxcar_dump u_boxcar (
    .clk          (clk),
    .rst          (rst),
    .en_i         (bus.enable_i),
    .v2_i         (v2_q),
    .prod_i       (prod_q),
    .avg_log2_i   (bus.avg_log2_i),
    .gain_shift_i (bus.gain_shift_i),
    .offset_i     (bus.offset_i),
    .dump_vld_o   (dump_vld),
    .dump_dat_o   (dump_dat),
    .dump_sat_o   (dump_sat)
  );

  assign bus.err_o       = err_q;
  assign bus.err_valid_o = err_valid_q;
  assign bus.sat_o       = sat_q;
endmodule

// File: tb/tb_pdh_err_demod.sv
// Directed bench for pdh_err_demod: expected dumps (value, sat, edge index) are queued at stimulus time
// and a negedge monitor pops one per err_valid_o pulse.
module tb_pdh_err_demod;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  typedef struct {
    int err;
    bit sat;
    int cyc;
  } exp_t;
  exp_t sb[$];

  pdh_err_demod_if bus();

  pdh_err_demod dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", nm, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (!rst && bus.err_valid_o) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("err_o", int'($signed(bus.err_o)), e.err);
        chk("sat_o", int'(bus.sat_o), int'(e.sat));
        chk("pulse_edge", cyc, e.cyc);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int e, input bit s, input int c);
    sb.push_back('{err: e, sat: s, cyc: c});
  endtask

  task automatic set_cfg(input int avg, input int gain, input int off);
    bus.avg_log2_i   = 4'(avg);
    bus.gain_shift_i = 4'(gain);
    bus.offset_i     = 14'(off);
  endtask

  task automatic finish_run(input string nm);
    bus.enable_i = 1'b0;
    step(2);
    chk({nm, "_err_cleared"}, int'($signed(bus.err_o)), 0);
    chk({nm, "_sat_cleared"}, int'(bus.sat_o), 0);
    chk({nm, "_queue_empty"}, sb.size(), 0);
  endtask

  // Runs nwin complete windows with adc/lo alternating between phase-0 and phase-1 values.
  task automatic run_win(input string nm, input int a0, input int a1, input int l0, input int l1,
                         input int avg, input int gain, input int off, input int nwin,
                         input int exp_err, input bit exp_sat);
    int n;
    int c0;
    n = 1 << avg;
    set_cfg(avg, gain, off);
    bus.enable_i = 1'b1;
    c0 = cyc;
    for (int i = 0; i < nwin; i++) push(exp_err, exp_sat, c0 + n * (i + 1) + 2);
    for (int s = 0; s < n * nwin + 2; s++) begin
      bus.adc_i = 14'((s % 2 == 0) ? a0 : a1);
      bus.lo_i  = 16'((s % 2 == 0) ? l0 : l1);
      step(1);
    end
    finish_run(nm);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at edge %0d", cyc);
    $fatal(1);
  end

  initial begin
    int c0;
    bus.adc_i = '0;
    bus.lo_i = '0;
    bus.enable_i = 1'b0;
    set_cfg(0, 0, 0);

    step(2);
    chk("rst_err", int'($signed(bus.err_o)), 0);
    chk("rst_vld", int'(bus.err_valid_o), 0);
    chk("rst_sat", int'(bus.sat_o), 0);
    #2 rst = 1'b0;
    step(2);

    // T1 DC gain, first pulse at edge 6 after enable, then every 4th.
    run_win("t1_dc", 1000, 1000, 32767, 32767, 2, 0, 0, 3, 1000, 1'b0);
    run_win("dc_neg", -1000, -1000, 32767, 32767, 2, 0, 0, 2, -1000, 1'b0);
    run_win("n1", 1000, 1000, 32767, 32767, 0, 0, 0, 3, 1000, 1'b0);

    // T2 phase sensitivity.
    run_win("t2_inphase", 2000, -2000, 32767, -32768, 1, 0, 0, 3, 2000, 1'b0);
    run_win("t2_const", 2000, 2000, 32767, -32768, 1, 0, 0, 3, 0, 1'b0);

    // T3 saturation and offset.
    run_win("t3_pos", 8191, 8191, 32767, 32767, 2, 4, 0, 2, 8191, 1'b1);
    run_win("t3_neg", -8192, -8192, 32767, 32767, 2, 4, 0, 2, -8192, 1'b1);
    run_win("t3_off", 1000, 1000, 32767, 32767, 2, 0, 100, 2, 1100, 1'b0);

    // T4 disable mid-window at cnt=7 of the second N=16 window.
    set_cfg(4, 0, 0);
    bus.adc_i = 14'(1000);
    bus.lo_i  = 16'(32767);
    bus.enable_i = 1'b1;
    c0 = cyc;
    push(1000, 1'b0, c0 + 18);
    step(25);
    chk("t4_err_before", int'($signed(bus.err_o)), 1000);
    bus.enable_i = 1'b0;
    step(3);
    chk("t4_err_off", int'($signed(bus.err_o)), 0);
    chk("t4_queue_off", sb.size(), 0);
    bus.enable_i = 1'b1;
    c0 = cyc;
    push(1000, 1'b0, c0 + 18);
    step(18);
    finish_run("t4");

    // Enable dropped right before the dump edge: no pulse.
    set_cfg(2, 0, 0);
    bus.enable_i = 1'b1;
    step(5);
    finish_run("fall_on_dump");

    // T5 async reset between edges mid-window.
    bus.enable_i = 1'b1;
    c0 = cyc;
    push(1000, 1'b0, c0 + 6);
    step(8);
    chk("t5_err_before", int'($signed(bus.err_o)), 1000);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_err", int'($signed(bus.err_o)), 0);
    chk("t5_rst_vld", int'(bus.err_valid_o), 0);
    chk("t5_rst_sat", int'(bus.sat_o), 0);
    step(1);
    #2 rst = 1'b0;
    c0 = cyc;
    push(1000, 1'b0, c0 + 6);
    push(1000, 1'b0, c0 + 10);
    step(10);
    finish_run("t5");

    // T6 config change at cnt=1: window 1 keeps N=4/gain 0, later windows use N=2/gain 1.
    set_cfg(2, 0, 0);
    bus.enable_i = 1'b1;
    c0 = cyc;
    push(1000, 1'b0, c0 + 6);
    push(2000, 1'b0, c0 + 8);
    push(2000, 1'b0, c0 + 10);
    step(3);
    set_cfg(1, 1, 0);
    step(7);
    finish_run("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
